key_request_latch: RTL

- Upstream stage of the 8-3 priority encoder: conditions eight raw active-low key lines into stable, latched, active-low request lines.
- Its output drives the encoder's data input directly. Its enable output drives the encoder's enable input.
- The encoder's 3-bit code is fed back as an acknowledge, which clears the served request so the next-priority key is presented.

---
 rtl/key_request_latch.sv | 92 +++++++++
 1 files changed

// File: rtl/key_request_latch.sv
// Key conditioning ahead of the 8-3 priority encoder: synchronize, debounce and
// latch active-low key presses; the encoder's code acknowledges the served request.
module key_request_latch #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [7:0] iKey,
   input  logic       iEnable,
   input  logic       iAckValid,
   input  logic [2:0] iAckCode,
   output logic [7:0] oReq,
   output logic       oEI,
   output logic       oAny
);

   localparam int unsigned NKEY  = 8;
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [NKEY-1:0]  sync1;
   logic [NKEY-1:0]  sync2;
   logic [NKEY-1:0]  acc;
   logic [NKEY-1:0]  acc_next;
   logic [NKEY-1:0]  press;
   logic [NKEY-1:0]  ack_clr;
   logic [NKEY-1:0]  pending;
   logic [NKEY-1:0]  pend_next;
   logic [NKEY-1:0]  req;
   logic             any;
   logic             ei;
   logic [CNT_W-1:0] cnt      [NKEY];
   logic [CNT_W-1:0] cnt_next [NKEY];

   // Per-bit debounce: a level is accepted only after DB_CYCLES consecutive mismatches
   always_comb begin
      acc_next = acc;
      press    = '0;
      for (int i = 0; i < NKEY; i++) begin
         cnt_next[i] = '0;
         if (sync2[i] != acc[i]) begin
            if (cnt[i] == CNT_LAST) begin
               acc_next[i] = sync2[i];
               press[i]    = ~sync2[i];
            end else begin
               cnt_next[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Code 000 serves bit 7, code 111 serves bit 0
   always_comb begin
      ack_clr = '0;
      if (iAckValid) begin
         ack_clr[3'd7 - iAckCode] = 1'b1;
      end
   end

   // A press landing on the same edge as its ack keeps the bit pending
   assign pending   = ~req;
   assign pend_next = (pending & ~ack_clr) | press;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         sync1 <= '1;
         sync2 <= '1;
         acc   <= '1;
         req   <= '1;
         any   <= 1'b0;
         ei    <= 1'b1;
         for (int i = 0; i < NKEY; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= iKey;
         sync2 <= sync1;
         acc   <= acc_next;
         req   <= ~pend_next;
         any   <= |pend_next;
         ei    <= ~iEnable;
         for (int i = 0; i < NKEY; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   assign oReq = req;
   assign oAny = any;
   assign oEI  = ei;

endmodule
